// File: rtl/pluto_pkg.sv
// Shared definitions for the PWM command path: command-word layout and scheduler states.
package pluto_pkg;

  localparam int CMD_W    = 16;
  localparam int DUTY_MSB = 10;
  localparam int UPINV    = 12;
  localparam int DNINV    = 13;
  localparam int DITHER   = 14;
  localparam int DIR      = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  // Duty and direction forced to zero; inversion/dither kept so outputs rest at idle polarity.
  function automatic logic [CMD_W-1:0] idle_word(input logic [CMD_W-1:0] w);
    logic [CMD_W-1:0] r;
    r = w;
    r[DUTY_MSB:0] = '0;
    r[DIR] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pwm_wd_timer.sv
// Saturating PWM-period counter; expire pulses on the period_end that makes it reach WD_PERIODS.
module pwm_wd_timer #(
  parameter int WD_PERIODS = 200,
  parameter int WD_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam logic [WD_W-1:0] SAT  = WD_W'(WD_PERIODS);
  localparam logic [WD_W-1:0] LAST = WD_W'(WD_PERIODS - 1);
  localparam logic            ENABLE = (WD_PERIODS != 0);

  logic [WD_W-1:0] count_reg;

  // Expiry is independent of clear so the top can let a trip veto a same-cycle commit.
  assign expire = ENABLE && inc && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != SAT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_update_sched.sv
// Shadowed PWM command words, transferred atomically on a period boundary after commit,
// with a watchdog that parks all channels at zero duty if commits stop arriving.
module pwm_update_sched
  import pluto_pkg::*;
#(
  parameter int NCHAN      = 4,
  parameter int WD_PERIODS = 200,
  parameter int WD_W       = 8,
  localparam int CHAN_W    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [CHAN_W-1:0]      wr_chan,
  input  logic [CMD_W-1:0]       wr_data,
  input  logic                   commit,
  input  logic                   wd_clear,
  input  logic                   period_end,
  output logic [CMD_W*NCHAN-1:0] pwm_active,
  output logic [NCHAN-1:0]       pending,
  output logic                   armed,
  output logic                   wd_tripped
);

  state_t state_reg, state_next;

  logic [CMD_W-1:0] shadow_reg [NCHAN];
  logic [CMD_W-1:0] active_reg [NCHAN];
  logic [NCHAN-1:0] pending_reg;

  logic expire;
  logic trip;
  logic commit_ok;
  logic transfer;

  pwm_wd_timer #(
    .WD_PERIODS (WD_PERIODS),
    .WD_W       (WD_W)
  ) u_wd_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (commit_ok || wd_clear),
    .inc    (period_end),
    .expire (expire)
  );

  // A wd_clear in the same cycle as an expiry counts as a fresh start, not a trip.
  assign trip      = expire && !wd_clear;
  assign commit_ok = commit && !trip &&
                     ((state_reg == IDLE) || ((state_reg == TRIPPED) && wd_clear));
  assign transfer  = (state_reg == ARMED) && period_end && !trip;

  always_comb begin
    state_next = state_reg;
    if (trip) begin
      state_next = TRIPPED;
    end else begin
      case (state_reg)
        IDLE:    if (commit_ok) state_next = ARMED;
        ARMED:   if (period_end) state_next = IDLE;
        TRIPPED: if (wd_clear) state_next = commit_ok ? ARMED : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      logic wr_hit;
      assign wr_hit = wr_en && (wr_chan == CHAN_W'(gi));

      // Transfer uses the pre-write shadow; a coincident write stays pending for next time.
      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_reg[gi]  <= '0;
          active_reg[gi]  <= '0;
          pending_reg[gi] <= 1'b0;
        end else begin
          if (trip) begin
            active_reg[gi] <= idle_word(active_reg[gi]);
          end else if (transfer && pending_reg[gi]) begin
            active_reg[gi] <= shadow_reg[gi];
          end
          if (wr_hit) begin
            shadow_reg[gi]  <= wr_data;
            pending_reg[gi] <= 1'b1;
          end else if (transfer) begin
            pending_reg[gi] <= 1'b0;
          end
        end
      end

      assign pwm_active[gi*CMD_W +: CMD_W] = active_reg[gi];
    end
  endgenerate

  assign pending    = pending_reg;
  assign armed      = (state_reg == ARMED);
  assign wd_tripped = (state_reg == TRIPPED);

endmodule
